// File: rtl/hazard_forward_ctrl_pkg.sv
// rtl/hazard_forward_ctrl_pkg.sv - shared forwarding encodings and register-match helper
package hazard_forward_ctrl_pkg;

  localparam logic [1:0] FWD_RF   = 2'd0;
  localparam logic [1:0] FWD_WB   = 2'd1;
  localparam logic [1:0] FWD_MEM  = 2'd2;
  localparam logic [4:0] REG_ZERO = 5'd0;

  // A later stage produces a value the reader needs; $0 is hard-wired so it never matches.
  function automatic logic regHit(input logic we, input logic [4:0] dst, input logic [4:0] src);
    return we && (dst != REG_ZERO) && (dst == src);
  endfunction

endpackage

// File: rtl/hazard_md_counter.sv
// rtl/hazard_md_counter.sv - mult/div busy counter, reloaded on every MDU start
module hazard_md_counter #(
  parameter int MD_LAT = 32
) (
  input  logic clk,
  input  logic rst,
  input  logic MdStartE,
  output logic MdBusy
);

  localparam logic [5:0] LAT = 6'(MD_LAT);

  logic [5:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= 6'd0;
    end else if (MdStartE) begin
      cnt <= LAT;
    end else if (cnt != 6'd0) begin
      cnt <= cnt - 6'd1;
    end
  end

  assign MdBusy = (cnt != 6'd0);

endmodule

// File: rtl/hazard_forward_ctrl.sv
// rtl/hazard_forward_ctrl.sv - operand forwarding, stall/flush generation and stall counting
module hazard_forward_ctrl
  import hazard_forward_ctrl_pkg::*;
#(
  parameter int MD_LAT = 32,
  parameter int CNT_W  = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       RsD,
  input  logic [4:0]       RtD,
  input  logic [4:0]       RsE,
  input  logic [4:0]       RtE,
  input  logic [4:0]       WriteRegE,
  input  logic             RegWriteE,
  input  logic             MemtoRegE,
  input  logic [4:0]       WriteRegM,
  input  logic             RegWriteM,
  input  logic             MemtoRegM,
  input  logic [4:0]       WriteRegW,
  input  logic             RegWriteW,
  input  logic             BranchD,
  input  logic             MdUseD,
  input  logic             MdStartE,
  output logic [1:0]       ForwardAE,
  output logic [1:0]       ForwardBE,
  output logic             ForwardAD,
  output logic             ForwardBD,
  output logic             StallF,
  output logic             StallD,
  output logic             FlushE,
  output logic             MdBusy,
  output logic [CNT_W-1:0] StallCnt
);

  logic lwStall;
  logic brStall;
  logic mdStall;
  logic anyStall;

  hazard_md_counter #(.MD_LAT(MD_LAT)) uMdCounter (
    .clk      (clk),
    .rst      (rst),
    .MdStartE (MdStartE),
    .MdBusy   (MdBusy)
  );

  // M holds the newest result, so it wins over W for the same register.
  always_comb begin
    ForwardAE = FWD_RF;
    ForwardBE = FWD_RF;
    if (!rst) begin
      if (regHit(RegWriteM, WriteRegM, RsE))      ForwardAE = FWD_MEM;
      else if (regHit(RegWriteW, WriteRegW, RsE)) ForwardAE = FWD_WB;
      if (regHit(RegWriteM, WriteRegM, RtE))      ForwardBE = FWD_MEM;
      else if (regHit(RegWriteW, WriteRegW, RtE)) ForwardBE = FWD_WB;
    end
  end

  assign ForwardAD = !rst && regHit(RegWriteM, WriteRegM, RsD);
  assign ForwardBD = !rst && regHit(RegWriteM, WriteRegM, RtD);

  assign lwStall = MemtoRegE &&
                   (regHit(RegWriteE, WriteRegE, RsD) || regHit(RegWriteE, WriteRegE, RtD));

  // A branch resolves in D, so an ALU result still in E or load data still in M is too late.
  assign brStall = BranchD &&
                   (regHit(RegWriteE, WriteRegE, RsD) || regHit(RegWriteE, WriteRegE, RtD) ||
                    regHit(MemtoRegM, WriteRegM, RsD) || regHit(MemtoRegM, WriteRegM, RtD));

  // The counter only loads at the end of the start cycle, so MdStartE covers that first cycle.
  assign mdStall = MdUseD && (MdBusy || MdStartE);

  assign anyStall = !rst && (lwStall || brStall || mdStall);
  assign StallF   = anyStall;
  assign StallD   = anyStall;
  assign FlushE   = rst || anyStall;

  always_ff @(posedge clk) begin
    if (rst) begin
      StallCnt <= '0;
    end else if (StallD && (StallCnt != {CNT_W{1'b1}})) begin
      StallCnt <= StallCnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_hazard_forward_ctrl.sv
// tb/tb_hazard_forward_ctrl.sv - directed vectors plus a per-cycle reference model of the hazard rules
module tb_hazard_forward_ctrl;

  localparam int TB_LAT   = 4;
  localparam int TB_CNT_W = 4;
  localparam int CNT_MAX  = (1 << TB_CNT_W) - 1;

  logic clk = 1'b0;
  logic rst;
  logic [4:0] RsD, RtD, RsE, RtE, WriteRegE, WriteRegM, WriteRegW;
  logic RegWriteE, MemtoRegE, RegWriteM, MemtoRegM, RegWriteW;
  logic BranchD, MdUseD, MdStartE;
  logic [1:0] ForwardAE, ForwardBE;
  logic ForwardAD, ForwardBD, StallF, StallD, FlushE, MdBusy;
  logic [TB_CNT_W-1:0] StallCnt;

  int tests = 0;
  int fails = 0;
  bit checkEn = 1'b0;
  int mdRemain = 0;
  int stallTotal = 0;

  always #5 clk = ~clk;

  hazard_forward_ctrl #(.MD_LAT(TB_LAT), .CNT_W(TB_CNT_W)) dut (
    .clk(clk), .rst(rst),
    .RsD(RsD), .RtD(RtD), .RsE(RsE), .RtE(RtE),
    .WriteRegE(WriteRegE), .RegWriteE(RegWriteE), .MemtoRegE(MemtoRegE),
    .WriteRegM(WriteRegM), .RegWriteM(RegWriteM), .MemtoRegM(MemtoRegM),
    .WriteRegW(WriteRegW), .RegWriteW(RegWriteW),
    .BranchD(BranchD), .MdUseD(MdUseD), .MdStartE(MdStartE),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE), .ForwardAD(ForwardAD), .ForwardBD(ForwardBD),
    .StallF(StallF), .StallD(StallD), .FlushE(FlushE), .MdBusy(MdBusy), .StallCnt(StallCnt)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Does a stage that writes register dst feed a reader of src?
  function automatic bit feeds(input logic we, input logic [4:0] dst, input logic [4:0] src);
    return (we == 1'b1) && (dst != 5'd0) && (dst == src);
  endfunction

  function automatic int expFwdE(input logic [4:0] src);
    if (rst) return 0;
    if (feeds(RegWriteM, WriteRegM, src)) return 2;
    if (feeds(RegWriteW, WriteRegW, src)) return 1;
    return 0;
  endfunction

  function automatic bit expStall();
    bit lw, br, md;
    lw = MemtoRegE && (feeds(RegWriteE, WriteRegE, RsD) || feeds(RegWriteE, WriteRegE, RtD));
    br = BranchD && (feeds(RegWriteE, WriteRegE, RsD) || feeds(RegWriteE, WriteRegE, RtD) ||
                     feeds(MemtoRegM, WriteRegM, RsD) || feeds(MemtoRegM, WriteRegM, RtD));
    md = MdUseD && ((mdRemain > 0) || MdStartE);
    return !rst && (lw || br || md);
  endfunction

  always @(negedge clk) begin
    bit st;
    st = expStall();
    if (checkEn) begin
      check("model_ForwardAE", 32'(ForwardAE), 32'(expFwdE(RsE)));
      check("model_ForwardBE", 32'(ForwardBE), 32'(expFwdE(RtE)));
      check("model_ForwardAD", 32'(ForwardAD), 32'(!rst && feeds(RegWriteM, WriteRegM, RsD)));
      check("model_ForwardBD", 32'(ForwardBD), 32'(!rst && feeds(RegWriteM, WriteRegM, RtD)));
      check("model_StallF", 32'(StallF), 32'(st));
      check("model_StallD", 32'(StallD), 32'(st));
      check("model_FlushE", 32'(FlushE), 32'(rst || st));
      check("model_MdBusy", 32'(MdBusy), 32'(mdRemain > 0));
      check("model_StallCnt", 32'(StallCnt), 32'(stallTotal));
    end
    if (rst) begin
      mdRemain = 0;
      stallTotal = 0;
    end else begin
      if (MdStartE) mdRemain = TB_LAT;
      else if (mdRemain > 0) mdRemain--;
      if (st && stallTotal < CNT_MAX) stallTotal++;
    end
  end

  task automatic clr();
    rst = 1'b0;
    {RsD, RtD, RsE, RtE, WriteRegE, WriteRegM, WriteRegW} = '0;
    {RegWriteE, MemtoRegE, RegWriteM, MemtoRegM, RegWriteW} = '0;
    {BranchD, MdUseD, MdStartE} = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    clr();
  endtask

  initial begin
    clr();
    rst = 1'b1;
    @(posedge clk);
    #1;
    checkEn = 1'b1;
    @(negedge clk);
    check("rst_FlushE", 32'(FlushE), 1);
    check("rst_StallD", 32'(StallD), 0);
    check("rst_MdBusy", 32'(MdBusy), 0);
    check("rst_StallCnt", 32'(StallCnt), 0);

    // forwarding priority and $0
    tick(); RegWriteM = 1; WriteRegM = 3; RegWriteW = 1; WriteRegW = 3; RsE = 3; RtE = 3; RtD = 3;
    @(negedge clk);
    check("fwd_AE_mem", 32'(ForwardAE), 2);
    check("fwd_BE_mem", 32'(ForwardBE), 2);
    check("fwd_BD_mem", 32'(ForwardBD), 1);
    check("fwd_no_stall", 32'(StallD), 0);
    tick(); WriteRegM = 3; RegWriteW = 1; WriteRegW = 3; RsE = 3;
    @(negedge clk);
    check("fwd_AE_wb", 32'(ForwardAE), 1);
    tick(); RegWriteM = 1; RegWriteW = 1;
    @(negedge clk);
    check("fwd_AE_zero", 32'(ForwardAE), 0);
    check("fwd_AD_zero", 32'(ForwardAD), 0);

    // load-use
    tick(); MemtoRegE = 1; RegWriteE = 1; WriteRegE = 5; RtD = 5;
    @(negedge clk);
    check("lw_StallF", 32'(StallF), 1);
    check("lw_StallD", 32'(StallD), 1);
    check("lw_FlushE", 32'(FlushE), 1);
    tick(); MemtoRegM = 1; RegWriteM = 1; WriteRegM = 5; RtD = 5;
    @(negedge clk);
    check("lw_release", 32'(StallD), 0);
    tick(); RegWriteW = 1; WriteRegW = 5; RtE = 5;
    @(negedge clk);
    check("lw_BE_wb", 32'(ForwardBE), 1);

    // branch on ALU result, then on a load
    tick(); BranchD = 1; RsD = 4; RegWriteE = 1; WriteRegE = 4;
    @(negedge clk);
    check("br_alu_stall", 32'(StallD), 1);
    tick(); BranchD = 1; RsD = 4; RegWriteM = 1; WriteRegM = 4;
    @(negedge clk);
    check("br_alu_release", 32'(StallD), 0);
    check("br_alu_AD", 32'(ForwardAD), 1);
    tick(); BranchD = 1; RsD = 4; MemtoRegE = 1; RegWriteE = 1; WriteRegE = 4;
    @(negedge clk);
    check("br_lw_stall1", 32'(StallD), 1);
    tick(); BranchD = 1; RsD = 4; MemtoRegM = 1; RegWriteM = 1; WriteRegM = 4;
    @(negedge clk);
    check("br_lw_stall2", 32'(StallD), 1);
    tick(); BranchD = 1; RsD = 4; RegWriteW = 1; WriteRegW = 4;
    @(negedge clk);
    check("br_lw_release", 32'(StallD), 0);
    check("br_lw_AD", 32'(ForwardAD), 0);

    // mult in E, mflo waiting in D
    for (int i = 0; i < 6; i++) begin
      tick(); MdUseD = 1; MdStartE = (i == 0);
      @(negedge clk);
      check($sformatf("md_stall_%0d", i), 32'(StallD), 32'(i < 5));
      check($sformatf("md_busy_%0d", i), 32'(MdBusy), 32'(i >= 1 && i <= 4));
    end
    check("md_stallcnt", 32'(StallCnt), 9);

    // reset in the middle of an MDU operation
    tick(); MdStartE = 1;
    @(negedge clk);
    tick(); MdUseD = 1;
    @(negedge clk);
    check("rstmd_pre_stall", 32'(StallD), 1);
    tick(); rst = 1; MdUseD = 1; RegWriteM = 1; WriteRegM = 6; RsE = 6;
    MemtoRegE = 1; RegWriteE = 1; WriteRegE = 6; RsD = 6;
    @(negedge clk);
    check("rstmd_StallD", 32'(StallD), 0);
    check("rstmd_StallF", 32'(StallF), 0);
    check("rstmd_FlushE", 32'(FlushE), 1);
    check("rstmd_AE", 32'(ForwardAE), 0);
    check("rstmd_busy_held", 32'(MdBusy), 1);
    check("rstmd_cnt_held", 32'(StallCnt), 10);
    tick(); MdUseD = 1;
    @(negedge clk);
    check("rstmd_MdBusy", 32'(MdBusy), 0);
    check("rstmd_StallCnt", 32'(StallCnt), 0);
    check("rstmd_no_stall", 32'(StallD), 0);

    // saturation of the stall counter
    for (int i = 0; i < 20; i++) begin
      tick(); MemtoRegE = 1; RegWriteE = 1; WriteRegE = 7; RsD = 7;
      @(negedge clk);
      if (i == 14) check("sat_cnt_14", 32'(StallCnt), 14);
      if (i == 16) check("sat_cnt_16", 32'(StallCnt), 15);
    end
    tick();
    @(negedge clk);
    check("sat_final", 32'(StallCnt), 15);
    check("sat_release", 32'(StallD), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
